// File: rtl/sha_sched_ctrl_pkg.sv
// Shared constants for the SHA block sequencer: FSM state codes, hash-size codes
// and per-algorithm round counts.
package sha_sched_ctrl_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ROUND = 2'd1;
  localparam logic [1:0] STATE_FINAL = 2'd2;

  localparam logic [1:0] HS_256 = 2'b00;
  localparam logic [1:0] HS_384 = 2'b10;
  localparam logic [1:0] HS_512 = 2'b11;

  localparam int unsigned DEF_CNT_W    = 7;
  localparam int unsigned DEF_WIN_W    = 1024;
  localparam int unsigned DEF_RNDS_256 = 64;
  localparam int unsigned DEF_RNDS_512 = 80;

endpackage

// File: rtl/sha_sched_ctrl_round_counter.sv
// Round counter: cleared on abort or block start, counts while enabled and
// saturates at n-1 so the index never wraps.
module sha_round_counter #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] cnt,
  output logic             last_rnd
);

  assign last_rnd = (cnt == n - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || start) begin
      cnt <= '0;
    end else if (en && !last_rnd) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sha_sched_ctrl.sv
// Block sequencer for one SHA-256/384/512 message scheduler: accepts a block,
// loads the scheduler, then walks the round index and flags block/digest completion.
module sha_sched_ctrl
  import sha_sched_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned WIN_W    = DEF_WIN_W,
  parameter int unsigned RNDS_256 = DEF_RNDS_256,
  parameter int unsigned RNDS_512 = DEF_RNDS_512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [WIN_W-1:0] blk_data,
  input  logic             blk_first,
  input  logic             blk_last,
  input  logic [1:0]       hash_size,
  output logic             sch_start,
  output logic             sch_load,
  output logic [WIN_W-1:0] sch_win,
  output logic [1:0]       sch_hsize,
  output logic [CNT_W-1:0] rnd_cnt,
  output logic             rnd_valid,
  output logic             rnd_first,
  output logic             blk_done,
  output logic             digest_valid,
  output logic             busy
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             rdy_en_q;
  logic [1:0]       hsize_q;
  logic             first_q;
  logic             last_q;
  logic             accept;
  logic             in_round;
  logic             in_final;
  logic [CNT_W-1:0] n_rnds;
  logic             last_rnd;

  assign in_round  = (state_q == STATE_ROUND);
  assign in_final  = (state_q == STATE_FINAL);
  assign blk_ready = rdy_en_q & (state_q == STATE_IDLE) & ~clr;
  assign accept    = blk_valid & blk_ready;

  // Round count follows the latched size, so hash_size changes mid-block are ignored.
  assign n_rnds = hsize_q[1] ? CNT_W'(RNDS_512) : CNT_W'(RNDS_256);

  sha_round_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .start    (accept),
    .en       (in_round),
    .n        (n_rnds),
    .cnt      (rnd_cnt),
    .last_rnd (last_rnd)
  );

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = STATE_IDLE;
    end else begin
      case (state_q)
        STATE_IDLE:  if (accept) state_d = STATE_ROUND;
        STATE_ROUND: if (last_rnd) state_d = STATE_FINAL;
        STATE_FINAL: state_d = STATE_IDLE;
        default:     state_d = STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= STATE_IDLE;
      rdy_en_q <= 1'b0;
      hsize_q  <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      if (accept) begin
        hsize_q <= hash_size;
        first_q <= blk_first;
        last_q  <= blk_last;
      end
    end
  end

  assign sch_win      = accept ? blk_data : '0;
  assign sch_start    = accept & blk_first;
  assign sch_load     = accept & ~blk_first;
  assign sch_hsize    = hsize_q;
  assign rnd_first    = first_q;
  assign rnd_valid    = in_round;
  assign blk_done     = in_final & ~clr;
  assign digest_valid = in_final & ~clr & last_q;
  assign busy         = (state_q != STATE_IDLE);

endmodule
